// File: rtl/addpkg.sv
`default_nettype none
// ============================================================================
// Package     : addpkg
// Description : FP32 field types, pack/unpack helpers and scheduler types
//               shared by the FP add/subtract datapath and its scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package addpkg;

    localparam int FP_ERR_W = 3;

    // Error code bits reported on err_o
    localparam logic [FP_ERR_W-1:0] c_ERR_OVF = 3'b001;
    localparam logic [FP_ERR_W-1:0] c_ERR_UNF = 3'b010;
    localparam logic [FP_ERR_W-1:0] c_ERR_INV = 3'b100;

    localparam logic [31:0] c_QNAN_BITS = 32'h7FC0_0000;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] sig;
    } fp_t;

    typedef struct packed {
        fp_t  op1;
        fp_t  op2;
        logic opcode;
    } fp_req_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } sched_state_t;

    function automatic fp_t fpUnpack(input logic [31:0] bits);
        fp_t f;
        f.sign = bits[31];
        f.exp  = bits[30:23];
        f.sig  = bits[22:0];
        return f;
    endfunction

    function automatic logic [31:0] fpPack(input fp_t f);
        return {f.sign, f.exp, f.sig};
    endfunction

endpackage
`default_nettype wire

// File: rtl/add_sub_top.sv
`default_nettype none
// ============================================================================
// Module      : add_sub_top
// Description : Combinational FP32 add/subtract, round-to-nearest-even,
//               subnormal inputs and results flushed to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module add_sub_top
    import addpkg::*;
(
    input  logic                i_sign1,
    input  logic [7:0]          i_exp1,
    input  logic [22:0]         i_sig1,
    input  logic                i_sign2,
    input  logic [7:0]          i_exp2,
    input  logic [22:0]         i_sig2,
    input  logic                i_opcode,
    output fp_t                 fp_out,
    output logic [FP_ERR_W-1:0] err_o
);

    logic               w_sign2_eff;
    logic               w_nan1, w_nan2, w_inf1, w_inf2;
    logic [23:0]        w_man1, w_man2, w_man_big, w_man_small;
    logic               w_swap, w_sign_big, w_sign_small;
    logic [7:0]         w_exp_big, w_exp_small, w_exp_diff, w_shift;
    logic [53:0]        w_align_wide;
    logic [26:0]        w_big_ext, w_small_al, w_norm;
    logic [27:0]        w_raw;
    logic [4:0]         w_lz;
    logic signed [9:0]  w_exp_norm, w_exp_final;
    logic               w_round_up;
    logic [24:0]        w_rounded;
    logic [22:0]        w_frac_final;

    assign w_sign2_eff = i_sign2 ^ i_opcode;
    assign w_nan1 = (i_exp1 == 8'hFF) && (i_sig1 != '0);
    assign w_nan2 = (i_exp2 == 8'hFF) && (i_sig2 != '0);
    assign w_inf1 = (i_exp1 == 8'hFF) && (i_sig1 == '0);
    assign w_inf2 = (i_exp2 == 8'hFF) && (i_sig2 == '0);
    assign w_man1 = (i_exp1 == 8'd0) ? 24'd0 : {1'b1, i_sig1};
    assign w_man2 = (i_exp2 == 8'd0) ? 24'd0 : {1'b1, i_sig2};

    assign w_swap       = {i_exp2, w_man2} > {i_exp1, w_man1};
    assign w_sign_big   = w_swap ? w_sign2_eff : i_sign1;
    assign w_sign_small = w_swap ? i_sign1 : w_sign2_eff;
    assign w_exp_big    = w_swap ? i_exp2 : i_exp1;
    assign w_exp_small  = w_swap ? i_exp1 : i_exp2;
    assign w_man_big    = w_swap ? w_man2 : w_man1;
    assign w_man_small  = w_swap ? w_man1 : w_man2;

    // Shifts of 27 or more all collapse the small operand into the sticky bit
    assign w_exp_diff   = w_exp_big - w_exp_small;
    assign w_shift      = (w_exp_diff > 8'd27) ? 8'd27 : w_exp_diff;
    assign w_big_ext    = {w_man_big, 3'b000};
    assign w_align_wide = {w_man_small, 3'b000, 27'd0} >> w_shift;
    assign w_small_al   = {w_align_wide[53:28], w_align_wide[27] | (|w_align_wide[26:0])};
    assign w_raw = (w_sign_big == w_sign_small) ? {1'b0, w_big_ext} + {1'b0, w_small_al}
                                                : {1'b0, w_big_ext} - {1'b0, w_small_al};

    always_comb begin
        w_lz = 5'd0;
        for (int i = 0; i < 27; i++) begin
            if (w_raw[i]) w_lz = 5'(26 - i);
        end
    end

    always_comb begin
        if (w_raw[27]) begin
            w_norm     = {w_raw[27:2], w_raw[1] | w_raw[0]};
            w_exp_norm = $signed({2'b00, w_exp_big}) + 10'sd1;
        end else begin
            w_norm     = w_raw[26:0] << w_lz;
            w_exp_norm = $signed({2'b00, w_exp_big}) - $signed({5'd0, w_lz});
        end
    end

    assign w_round_up   = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    assign w_rounded    = {1'b0, w_norm[26:3]} + {24'd0, w_round_up};
    assign w_exp_final  = w_rounded[24] ? w_exp_norm + 10'sd1 : w_exp_norm;
    assign w_frac_final = w_rounded[24] ? w_rounded[23:1] : w_rounded[22:0];

    always_comb begin
        fp_out = '0;
        err_o  = '0;
        if (w_nan1 || w_nan2 || (w_inf1 && w_inf2 && (i_sign1 != w_sign2_eff))) begin
            fp_out = fpUnpack(c_QNAN_BITS);
            err_o  = c_ERR_INV;
        end else if (w_inf1) begin
            fp_out = fpUnpack({i_sign1, 8'hFF, 23'd0});
        end else if (w_inf2) begin
            fp_out = fpUnpack({w_sign2_eff, 8'hFF, 23'd0});
        end else if (w_raw == '0) begin
            fp_out.sign = w_sign_big & w_sign_small;
        end else if (w_exp_final >= 10'sd255) begin
            fp_out = fpUnpack({w_sign_big, 8'hFF, 23'd0});
            err_o  = c_ERR_OVF;
        end else if (w_exp_final <= 10'sd0) begin
            fp_out.sign = w_sign_big;
            err_o       = c_ERR_UNF;
        end else begin
            fp_out = fpUnpack({w_sign_big, w_exp_final[7:0], w_frac_final});
        end
    end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin grant search starting one past the last grant.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_last_grant,
    output logic [NUM_REQ-1:0]         o_grant,
    output logic [$clog2(NUM_REQ)-1:0] o_grant_idx,
    output logic                       o_any
);

    localparam int c_IDX_W = $clog2(NUM_REQ);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_REQ - 1);

    logic [c_IDX_W-1:0] w_cand;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        w_cand      = i_last_grant;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = (w_cand == c_LAST_IDX) ? '0 : w_cand + 1'b1;
            if (!o_any && i_req[w_cand]) begin
                o_any           = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_grant_idx     = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_addsub_sched.sv
`default_nettype none
// ============================================================================
// Module      : fp_addsub_sched
// Description : Round-robin scheduler sharing one FP32 add/sub unit between
//               NUM_REQ requesters, with a saturating error-event counter.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_addsub_sched
    import addpkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int COMPUTE_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ-1:0][31:0] req_op1,
    input  logic [NUM_REQ-1:0][31:0] req_op2,
    input  logic [NUM_REQ-1:0]       req_opcode,
    output logic [NUM_REQ-1:0]       rsp_valid,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    output logic [31:0]              rsp_result,
    output logic [FP_ERR_W-1:0]      rsp_err,
    output logic                     busy,
    output logic [15:0]              err_count
);

    localparam int c_IDX_W = $clog2(NUM_REQ);
    localparam int c_CNT_W = (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_REQ - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(COMPUTE_CYCLES - 1);

    sched_state_t          r_state_q, w_state_d;
    logic [c_IDX_W-1:0]    r_last_grant_q, w_last_grant_d;
    logic [c_IDX_W-1:0]    r_grant_q, w_grant_d;
    logic [c_CNT_W-1:0]    r_cnt_q, w_cnt_d;
    fp_req_t               r_req_q, w_req_d;
    logic [31:0]           r_result_q, w_result_d;
    logic [FP_ERR_W-1:0]   r_err_q, w_err_d;
    logic [15:0]           r_err_count_q, w_err_count_d;

    logic [NUM_REQ-1:0]    w_arb_grant;
    logic [c_IDX_W-1:0]    w_arb_idx;
    logic                  w_arb_any;
    fp_t                   w_fp_out;
    logic [FP_ERR_W-1:0]   w_unit_err;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .i_req        (req_valid),
        .i_last_grant (r_last_grant_q),
        .o_grant      (w_arb_grant),
        .o_grant_idx  (w_arb_idx),
        .o_any        (w_arb_any)
    );

    add_sub_top u_unit (
        .i_sign1  (r_req_q.op1.sign),
        .i_exp1   (r_req_q.op1.exp),
        .i_sig1   (r_req_q.op1.sig),
        .i_sign2  (r_req_q.op2.sign),
        .i_exp2   (r_req_q.op2.exp),
        .i_sig2   (r_req_q.op2.sig),
        .i_opcode (r_req_q.opcode),
        .fp_out   (w_fp_out),
        .err_o    (w_unit_err)
    );

    always_comb begin
        w_state_d      = r_state_q;
        w_last_grant_d = r_last_grant_q;
        w_grant_d      = r_grant_q;
        w_cnt_d        = r_cnt_q;
        w_req_d        = r_req_q;
        w_result_d     = r_result_q;
        w_err_d        = r_err_q;
        w_err_count_d  = r_err_count_q;
        req_ready      = '0;
        rsp_valid      = '0;
        case (r_state_q)
            IDLE: begin
                req_ready = w_arb_grant;
                if (w_arb_any) begin
                    w_req_d.op1    = fpUnpack(req_op1[w_arb_idx]);
                    w_req_d.op2    = fpUnpack(req_op2[w_arb_idx]);
                    w_req_d.opcode = req_opcode[w_arb_idx];
                    w_grant_d      = w_arb_idx;
                    w_cnt_d        = c_CNT_LOAD;
                    w_state_d      = EXEC;
                end
            end
            EXEC: begin
                if (r_cnt_q != '0) begin
                    w_cnt_d = r_cnt_q - 1'b1;
                end else begin
                    w_result_d = fpPack(w_fp_out);
                    w_err_d    = w_unit_err;
                    if ((w_unit_err != '0) && (r_err_count_q != 16'hFFFF)) begin
                        w_err_count_d = r_err_count_q + 16'd1;
                    end
                    w_state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid[r_grant_q] = 1'b1;
                if (rsp_ready[r_grant_q]) begin
                    w_last_grant_d = r_grant_q;
                    w_state_d      = IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q      <= IDLE;
            r_last_grant_q <= c_LAST_IDX;
            r_grant_q      <= '0;
            r_cnt_q        <= '0;
            r_req_q        <= '0;
            r_result_q     <= '0;
            r_err_q        <= '0;
            r_err_count_q  <= '0;
        end else begin
            r_state_q      <= w_state_d;
            r_last_grant_q <= w_last_grant_d;
            r_grant_q      <= w_grant_d;
            r_cnt_q        <= w_cnt_d;
            r_req_q        <= w_req_d;
            r_result_q     <= w_result_d;
            r_err_q        <= w_err_d;
            r_err_count_q  <= w_err_count_d;
        end
    end

    assign rsp_result = r_result_q;
    assign rsp_err    = r_err_q;
    assign busy       = (r_state_q != IDLE);
    assign err_count  = r_err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_addsub_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_addsub_sched
// Description : Directed self-checking bench for fp_addsub_sched.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fp_addsub_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: COMPUTE_CYCLES = 1
    logic             rst;
    logic [1:0]       req_valid, req_ready, req_opcode, rsp_valid, rsp_ready;
    logic [1:0][31:0] req_op1, req_op2;
    logic [31:0]      rsp_result;
    logic [2:0]       rsp_err;
    logic             busy;
    logic [15:0]      err_count;

    // Instance B: COMPUTE_CYCLES = 4
    logic             b_rst;
    logic [1:0]       b_req_valid, b_req_ready, b_req_opcode, b_rsp_valid, b_rsp_ready;
    logic [1:0][31:0] b_req_op1, b_req_op2;
    logic [31:0]      b_rsp_result;
    logic [2:0]       b_rsp_err;
    logic             b_busy;
    logic [15:0]      b_err_count;

    int n_checks = 0;
    int n_errors = 0;

    fp_addsub_sched #(.NUM_REQ(2), .COMPUTE_CYCLES(1)) u_dut_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op1(req_op1), .req_op2(req_op2), .req_opcode(req_opcode),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_err(rsp_err),
        .busy(busy), .err_count(err_count)
    );

    fp_addsub_sched #(.NUM_REQ(2), .COMPUTE_CYCLES(4)) u_dut_b (
        .clk(clk), .rst(b_rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_op1(b_req_op1), .req_op2(b_req_op2), .req_opcode(b_req_opcode),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_result(b_rsp_result), .rsp_err(b_rsp_err),
        .busy(b_busy), .err_count(b_err_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One complete transaction on instance A; returns the response seen
    task automatic run_op(input logic idx, input logic [31:0] a, input logic [31:0] b,
                          input logic opc, output logic [1:0] vld, output logic [31:0] res,
                          output logic [2:0] err, output int wacc, output int lat);
        req_op1[idx] = a;
        req_op2[idx] = b;
        req_opcode[idx] = opc;
        req_valid[idx] = 1'b1;
        #1;
        wacc = 0;
        while (!req_ready[idx] && wacc < 50) begin
            @(negedge clk);
            wacc++;
        end
        @(posedge clk);
        #1;
        req_valid[idx] = 1'b0;
        lat = 1;
        @(negedge clk);
        while (rsp_valid == 2'b00 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        vld = rsp_valid;
        res = rsp_result;
        err = rsp_err;
        rsp_ready[idx] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[idx] = 1'b0;
    endtask

    logic [1:0]  vld, seen;
    logic [31:0] res;
    logic [2:0]  err;
    int          wacc, lat, w;
    int          n_srv[2];
    logic [31:0] exp_res[2];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;  b_rst = 1'b1;
        req_valid = '0;  req_opcode = '0;  rsp_ready = '0;  req_op1 = '0;  req_op2 = '0;
        b_req_valid = '0; b_req_opcode = '0; b_rsp_ready = '0; b_req_op1 = '0; b_req_op2 = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;  b_rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_result", rsp_result, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);

        // 2.0 + 2.0 on requester 0
        run_op(1'b0, 32'h4000_0000, 32'h4000_0000, 1'b0, vld, res, err, wacc, lat);
        chk("add_accept_wait", 32'(wacc), 32'd0);
        chk("add_latency", 32'(lat), 32'd2);
        chk("add_rsp_valid", 32'(vld), 32'd1);
        chk("add_result", res, 32'h4080_0000);
        chk("add_err", 32'(err), 32'd0);
        @(negedge clk);
        chk("add_idle_busy", 32'(busy), 32'd0);
        chk("add_idle_rsp_valid", 32'(rsp_valid), 32'd0);

        // 3.0 - 1.0 on requester 1
        run_op(1'b1, 32'h4040_0000, 32'h3F80_0000, 1'b1, vld, res, err, wacc, lat);
        chk("sub_rsp_valid", 32'(vld), 32'd2);
        chk("sub_result", res, 32'h4000_0000);
        chk("sub_err", 32'(err), 32'd0);

        // Overflow raises the error counter once; a clean op leaves it alone
        run_op(1'b0, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, vld, res, err, wacc, lat);
        chk("ovf_err_nonzero", 32'(err != 3'd0), 32'd1);
        chk("ovf_result", res, 32'h7F80_0000);
        chk("ovf_err_count", 32'(err_count), 32'd1);
        run_op(1'b0, 32'h4000_0000, 32'h4000_0000, 1'b0, vld, res, err, wacc, lat);
        chk("clean_err_count", 32'(err_count), 32'd1);
        chk("clean_result", res, 32'h4080_0000);

        // Backpressure with requester 1 waiting behind requester 0
        req_op1[0] = 32'h4000_0000; req_op2[0] = 32'h4000_0000; req_opcode[0] = 1'b0;
        req_valid[0] = 1'b1;
        #1;
        w = 0;
        while (!req_ready[0] && w < 50) begin @(negedge clk); w++; end
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        req_op1[1] = 32'h4040_0000; req_op2[1] = 32'h3F80_0000; req_opcode[1] = 1'b0;
        req_valid[1] = 1'b1;
        w = 0;
        @(negedge clk);
        while (rsp_valid == 2'b00 && w < 50) begin @(negedge clk); w++; end
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp_rsp_valid_%0d", c), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp_result_%0d", c), rsp_result, 32'h4080_0000);
            chk($sformatf("bp_err_%0d", c), 32'(rsp_err), 32'd0);
            chk($sformatf("bp_req_ready_%0d", c), 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[0] = 1'b0;
        chk("bp_next_grant", 32'(req_ready), 32'd2);
        run_op(1'b1, 32'h4040_0000, 32'h3F80_0000, 1'b0, vld, res, err, wacc, lat);
        chk("bp_req1_result", res, 32'h4080_0000);
        chk("bp_req1_valid", 32'(vld), 32'd2);

        // Fresh reset, then both requesters contend for four ops each
        rst = 1'b1;
        #1;
        chk("rst2_err_count", 32'(err_count), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_op1[0] = 32'h3F80_0000; req_op2[0] = 32'h3F80_0000; req_opcode[0] = 1'b0;
        req_op1[1] = 32'h4040_0000; req_op2[1] = 32'h3F80_0000; req_opcode[1] = 1'b0;
        exp_res[0] = 32'h4000_0000;
        exp_res[1] = 32'h4080_0000;
        n_srv[0] = 0; n_srv[1] = 0;
        req_valid = 2'b11;
        for (int k = 0; k < 8; k++) begin
            #1;
            w = 0;
            while (req_ready == 2'b00 && w < 50) begin @(negedge clk); w++; end
            seen = req_ready;
            chk($sformatf("cont_grant_%0d", k), 32'(seen), (k % 2 == 0) ? 32'd1 : 32'd2);
            if (k > 0) chk($sformatf("cont_gap_%0d", k), 32'(w), 32'd0);
            @(posedge clk);
            #1;
            n_srv[seen[1]]++;
            if (n_srv[seen[1]] == 4) req_valid[seen[1]] = 1'b0;
            w = 0;
            @(negedge clk);
            while (rsp_valid == 2'b00 && w < 50) begin @(negedge clk); w++; end
            chk($sformatf("cont_rsp_valid_%0d", k), 32'(rsp_valid), 32'(seen));
            chk($sformatf("cont_result_%0d", k), rsp_result, exp_res[seen[1]]);
            rsp_ready = 2'b11;
            @(posedge clk);
            #1;
            rsp_ready = 2'b00;
        end

        // Instance B: overflow op from requester 0 completes first
        b_req_op1[0] = 32'h7F7F_FFFF; b_req_op2[0] = 32'h7F7F_FFFF; b_req_opcode[0] = 1'b0;
        b_req_valid = 2'b01;
        #1;
        chk("b_first_grant", 32'(b_req_ready), 32'd1);
        @(posedge clk);
        #1;
        b_req_valid = 2'b00;
        lat = 1;
        @(negedge clk);
        while (b_rsp_valid == 2'b00 && lat < 50) begin @(negedge clk); lat++; end
        chk("b_latency", 32'(lat), 32'd5);
        chk("b_ovf_result", b_rsp_result, 32'h7F80_0000);
        chk("b_err_count", 32'(b_err_count), 32'd1);
        b_rsp_ready = 2'b01;
        @(posedge clk);
        #1;
        b_rsp_ready = 2'b00;

        // Requester 1 alone, then reset while its op is in EXEC
        b_req_op1[1] = 32'h4040_0000; b_req_op2[1] = 32'h3F80_0000; b_req_opcode[1] = 1'b1;
        b_req_valid = 2'b10;
        #1;
        chk("b_req1_grant", 32'(b_req_ready), 32'd2);
        @(posedge clk);
        #1;
        b_req_valid = 2'b00;
        @(posedge clk);
        #1;
        chk("b_in_exec", 32'(b_busy), 32'd1);
        b_rst = 1'b1;
        #1;
        chk("b_rst_busy", 32'(b_busy), 32'd0);
        chk("b_rst_rsp_valid", 32'(b_rsp_valid), 32'd0);
        chk("b_rst_result", b_rsp_result, 32'd0);
        chk("b_rst_err", 32'(b_rsp_err), 32'd0);
        chk("b_rst_err_count", 32'(b_err_count), 32'd0);
        chk("b_rst_req_ready", 32'(b_req_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        b_rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("b_no_rsp_%0d", c), 32'({b_busy, b_rsp_valid}), 32'd0);
        end
        b_req_op1[0] = 32'h4000_0000; b_req_op2[0] = 32'h4000_0000;
        b_req_valid = 2'b11;
        #1;
        chk("b_post_rst_grant", 32'(b_req_ready), 32'd1);
        @(posedge clk);
        #1;
        b_req_valid = 2'b00;
        w = 0;
        @(negedge clk);
        while (b_rsp_valid == 2'b00 && w < 50) begin @(negedge clk); w++; end
        chk("b_post_rst_valid", 32'(b_rsp_valid), 32'd1);
        chk("b_post_rst_result", b_rsp_result, 32'h4080_0000);
        b_rsp_ready = 2'b01;
        @(posedge clk);
        #1;
        b_rsp_ready = 2'b00;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
